// File: rtl/sha3_digest_reader.sv
// Captures the first DIGEST_LANES lanes of a Keccak state on sample and streams them one lane per beat.
// Latency: lane 0 is valid the cycle after the accepted sample. Throughput is one lane per cycle, with back-to-back digests.
// Backpressure: odata/olast hold while oready=0; a sample that cannot be accepted is dropped and sets overrun. SHA3_DIGEST_BSWAP_EN byte-reverses odata.
module sha3_digest_reader #(
    parameter int DIGEST_LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] isa [0:4],
    input  logic [63:0] isb [0:4],
    input  logic [63:0] isc [0:4],
    input  logic [63:0] isd [0:4],
    input  logic [63:0] ise [0:4],
    input  logic        sample,
    output logic        can_sample,
    output logic [63:0] odata,
    output logic        ovalid,
    input  logic        oready,
    output logic        olast,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int CW = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGEST_LANES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   lanes [25];
    logic [63:0]   cap   [DIGEST_LANES];
    logic          xfer;
    logic          at_last;
    logic          accept;
    logic          drop;

    function automatic logic [63:0] present(input logic [63:0] v);
`ifdef SHA3_DIGEST_BSWAP_EN
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = v[56-8*b +: 8];
        end
        return r;
`else
        return v;
`endif
    endfunction

    // Flatten rows so that lane index i = 5*y + x, i.e. A[i mod 5, i div 5].
    always_comb begin
        for (int x = 0; x < 5; x++) begin
            lanes[x]      = isa[x];
            lanes[5 + x]  = isb[x];
            lanes[10 + x] = isc[x];
            lanes[15 + x] = isd[x];
            lanes[20 + x] = ise[x];
        end
    end

    assign at_last = (cnt == LAST);
    assign xfer    = ovalid & oready;
    assign accept  = sample & can_sample;
    assign drop    = sample & ~can_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (sample) state_nxt = STREAM;
            STREAM: if (xfer && at_last) state_nxt = sample ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ovalid     = 1'b0;
        olast      = 1'b0;
        odata      = '0;
        can_sample = 1'b0;
        case (state)
            IDLE: begin
                can_sample = 1'b1;
            end
            STREAM: begin
                ovalid     = 1'b1;
                olast      = at_last;
                odata      = present(cap[cnt]);
                can_sample = oready & at_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DIGEST_LANES; i++) begin
                cap[i] <= '0;
            end
        end else if (accept) begin
            cnt <= '0;
            for (int i = 0; i < DIGEST_LANES; i++) begin
                cap[i] <= lanes[i];
            end
        end else if (xfer) begin
            cnt <= at_last ? '0 : cnt + CW'(1);
        end
    end

    // A dropped sample in the same cycle as a clear must still be reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha3_digest_reader.sv
// Bench for sha3_digest_reader: queue-based digest model checked every cycle, plus literal checks (4- and 8-lane instances).
module tb_sha3_digest_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] isa [0:4];
    logic [63:0] isb [0:4];
    logic [63:0] isc [0:4];
    logic [63:0] isd [0:4];
    logic [63:0] ise [0:4];
    logic        sample = 1'b0;
    logic        oready = 1'b1;
    logic        overrun_clr = 1'b0;
    logic        can_sample;
    logic [63:0] odata;
    logic        ovalid;
    logic        olast;
    logic        overrun;

    logic        sample8 = 1'b0;
    logic        oready8 = 1'b1;
    logic        can_sample8;
    logic [63:0] odata8;
    logic        ovalid8;
    logic        olast8;
    logic        overrun8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha3_digest_reader #(.DIGEST_LANES(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample), .can_sample(can_sample),
        .odata(odata), .ovalid(ovalid), .oready(oready), .olast(olast),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    sha3_digest_reader #(.DIGEST_LANES(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample8), .can_sample(can_sample8),
        .odata(odata8), .ovalid(ovalid8), .oready(oready8), .olast(olast8),
        .overrun(overrun8), .overrun_clr(1'b0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] present(input logic [63:0] v);
`ifdef SHA3_DIGEST_BSWAP_EN
        return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40], v[55:48], v[63:56]};
`else
        return v;
`endif
    endfunction

    // Lane i is A[i mod 5, i div 5]; row y is one of the is* buses.
    function automatic logic [63:0] get_lane(input int i);
        case (i / 5)
            0:       return isa[i % 5];
            1:       return isb[i % 5];
            2:       return isc[i % 5];
            3:       return isd[i % 5];
            default: return ise[i % 5];
        endcase
    endfunction

    task automatic load(input logic [63:0] base);
        for (int x = 0; x < 5; x++) begin
            isa[x] = base + 64'(x);
            isb[x] = base + 64'(5 + x);
            isc[x] = base + 64'(10 + x);
            isd[x] = base + 64'(15 + x);
            ise[x] = base + 64'(20 + x);
        end
    endtask

    task automatic load_fill(input logic [63:0] v);
        for (int x = 0; x < 5; x++) begin
            isa[x] = v; isb[x] = v; isc[x] = v; isd[x] = v; ise[x] = v;
        end
    endtask

    task automatic step(input logic s, input logic r, input logic c);
        @(negedge clk);
        sample      = s;
        oready      = r;
        overrun_clr = c;
    endtask

    // Model: the digest still owed to the sink, as a queue of lanes.
    logic [63:0] q [$];
    logic        m_ovr = 1'b0;
    logic        m_fire, m_last, m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovr = 1'b0;
        end else begin
            m_fire = (q.size() != 0) && oready;
            m_last = m_fire && (q.size() == 1);
            m_acc  = (q.size() == 0) || m_last;
            if (m_fire) void'(q.pop_front());
            if (sample && m_acc) begin
                for (int i = 0; i < 4; i++) q.push_back(get_lane(i));
            end
            if (sample && !m_acc) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        #2;
        chk("model ovalid", ovalid, q.size() != 0);
        if (q.size() != 0) begin
            chk("model odata", odata, present(q[0]));
            chk("model olast", olast, q.size() == 1);
        end
        chk("model can_sample", can_sample, (q.size() == 0) || (oready && q.size() == 1));
        chk("model overrun", overrun, m_ovr);
    end

    initial begin
        load(64'h0123_4567_89AB_CD00);

        // Reset state
        @(negedge clk); #2;
        chk("reset ovalid", ovalid, 0);
        chk("reset olast", olast, 0);
        chk("reset odata", odata, 0);
        chk("reset overrun", overrun, 0);
        chk("reset can_sample", can_sample, 1);
        rst_n = 1'b1;
        step(0, 1, 0);

        // Stream, no backpressure
        step(1, 1, 0);
        step(0, 1, 0); #2;
        chk("s1 c1 odata", odata, present(64'h0123_4567_89AB_CD00));
        chk("s1 c1 ovalid", ovalid, 1);
        chk("s1 c1 olast", olast, 0);
        step(0, 1, 0);
        step(0, 1, 0); #2;
        chk("s1 c3 olast", olast, 0);
        step(0, 1, 0); #2;
        chk("s1 c4 odata", odata, present(64'h0123_4567_89AB_CD03));
        chk("s1 c4 olast", olast, 1);
        step(0, 1, 0); #2;
        chk("s1 c5 ovalid", ovalid, 0);

        // Backpressure
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0); #2;
        chk("bp c3 odata", odata, present(64'h0123_4567_89AB_CD00));
        chk("bp c3 ovalid", ovalid, 1);
        step(0, 1, 0);
        step(0, 1, 0); #2;
        chk("bp c5 odata", odata, present(64'h0123_4567_89AB_CD01));
        step(0, 1, 0);
        step(0, 1, 0); #2;
        chk("bp c7 odata", odata, present(64'h0123_4567_89AB_CD03));
        step(0, 1, 0);

        // Overrun
        step(1, 1, 0);
        step(0, 1, 0);
        load_fill(64'hFFFF_FFFF_FFFF_FFFF);
        step(1, 1, 0);
        step(1, 1, 1); #2;
        chk("ovr c3 overrun", overrun, 1);
        step(0, 1, 0); #2;
        chk("ovr c4 overrun kept", overrun, 1);
        chk("ovr c4 odata", odata, present(64'h0123_4567_89AB_CD03));
        step(0, 1, 1);
        step(0, 1, 0); #2;
        chk("ovr cleared", overrun, 0);

        // Back-to-back
        load(64'h0123_4567_89AB_CD00);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        load(64'h0123_4567_89AB_EF00);
        step(1, 1, 0); #2;
        chk("b2b can_sample", can_sample, 1);
        step(0, 1, 0); #2;
        chk("b2b odata", odata, present(64'h0123_4567_89AB_EF00));
        chk("b2b ovalid", ovalid, 1);
        chk("b2b overrun", overrun, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 0);

        // Reset mid-stream
        load(64'h0123_4567_89AB_CD00);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        rst_n = 1'b0; #2;
        chk("rst ovalid", ovalid, 0);
        chk("rst odata", odata, 0);
        step(0, 1, 0);
        rst_n = 1'b1;
        step(0, 1, 0); #2;
        chk("rst no replay", ovalid, 0);
        step(1, 1, 0);
        step(0, 1, 0); #2;
        chk("rst restart odata", odata, present(64'h0123_4567_89AB_CD00));
        for (int k = 0; k < 4; k++) step(0, 1, 0);

        // Eight-lane digest
        @(negedge clk); sample8 = 1'b1;
        @(negedge clk); sample8 = 1'b0;
        #2 chk("d8 c1 odata", odata8, present(64'h0123_4567_89AB_CD00));
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk); #2;
            if (k == 6) chk("d8 lane5 isb0", odata8, present(64'h0123_4567_89AB_CD05));
            if (k == 7) chk("d8 c7 olast", olast8, 0);
            if (k == 8) begin
                chk("d8 c8 olast", olast8, 1);
                chk("d8 c8 odata", odata8, present(64'h0123_4567_89AB_CD07));
            end
            if (k == 9) chk("d8 c9 ovalid", ovalid8, 0);
        end
        chk("d8 overrun", overrun8, 0);

        // Byte order
        isa[0] = 64'h0011_2233_4455_6677;
        step(1, 1, 0);
        step(0, 1, 0); #2;
`ifdef SHA3_DIGEST_BSWAP_EN
        chk("bswap lane0", odata, 64'h7766_5544_3322_1100);
`else
        chk("plain lane0", odata, 64'h0011_2233_4455_6677);
`endif
        for (int k = 0; k < 5; k++) step(0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
